// File: rtl/segment_scan_decoder.sv
// +----------------------------------------------------------------------------+
// | Module      : segment_scan_decoder                                         |
// | Description : Recovers digit values from a multiplexed 4-digit 7-segment   |
// |               display bus by debouncing and decoding each digit slot.      |
// |               Define HEX_DECODE_EN to also accept the A..F glyphs.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module segment_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  segin,
   input  logic [3:0]  anin,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_valid,
   output logic        err
);

   localparam logic [7:0] c_stable   = 8'(STABLE_CYCLES);
   localparam logic [1:0] c_k_valid  = 2'd0;
   localparam logic [1:0] c_k_blank  = 2'd1;
   localparam logic [1:0] c_k_bad    = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      r_state, w_next_state;
   logic [6:0]  r_seg_s1, r_seg_s2, r_prev_seg;
   logic [3:0]  r_an_s1, r_an_s2, r_prev_an;
   logic [7:0]  r_cnt, w_next_cnt;
   logic [15:0] r_digits;
   logic [3:0]  r_valid, r_seen;
   logic        r_frame, r_err;

   logic [3:0]  w_sel, w_cap_mask, w_nib;
   logic [1:0]  w_idx, w_kind;
   logic        w_addr, w_same, w_capture;

   // Exactly one enable low: the inverted bus must be a non-zero power of two.
   assign w_sel  = ~r_an_s2;
   assign w_addr = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
   assign w_same = ({r_an_s2, r_seg_s2} == {r_prev_an, r_prev_seg});

   always_comb begin
      w_idx = 2'd0;
      case (w_sel)
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_addr) begin
               w_next_state = S_TRACK;
               w_next_cnt   = 8'd1;
            end
         end
         S_TRACK: begin
            if (!w_addr) begin
               w_next_state = S_IDLE;
               w_next_cnt   = 8'd0;
            end else if (!w_same) begin
               w_next_cnt   = 8'd1;
            end else if (r_cnt + 8'd1 == c_stable) begin
               w_next_state = S_HOLD;
               w_next_cnt   = c_stable;
               w_capture    = 1'b1;
            end else begin
               w_next_cnt   = r_cnt + 8'd1;
            end
         end
         S_HOLD: begin
            if (!w_same) begin
               w_next_state = w_addr ? S_TRACK : S_IDLE;
               w_next_cnt   = w_addr ? 8'd1 : 8'd0;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_nib  = 4'd0;
      w_kind = c_k_valid;
      case (r_seg_s2)
         7'b0000001: w_nib = 4'd0;
         7'b1001111: w_nib = 4'd1;
         7'b0010010: w_nib = 4'd2;
         7'b0000110: w_nib = 4'd3;
         7'b1001100: w_nib = 4'd4;
         7'b0100100: w_nib = 4'd5;
         7'b0100000: w_nib = 4'd6;
         7'b0001111: w_nib = 4'd7;
         7'b0000000: w_nib = 4'd8;
         7'b0000100: w_nib = 4'd9;
`ifdef HEX_DECODE_EN
         7'b0001000: w_nib = 4'd10;
         7'b1100000: w_nib = 4'd11;
         7'b0110001: w_nib = 4'd12;
         7'b1000010: w_nib = 4'd13;
         7'b0110000: w_nib = 4'd14;
         7'b0111000: w_nib = 4'd15;
`else
`endif
         7'b1111111: w_kind = c_k_blank;
         default:    w_kind = c_k_bad;
      endcase
   end

   assign w_cap_mask = w_capture ? (4'b0001 << w_idx) : 4'b0000;

   // Synchronizers idle at all-ones so the bus reads as "no digit selected".
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg_s1   <= '1;
         r_seg_s2   <= '1;
         r_an_s1    <= '1;
         r_an_s2    <= '1;
         r_prev_seg <= '1;
         r_prev_an  <= '1;
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_digits   <= 16'd0;
         r_valid    <= 4'd0;
         r_seen     <= 4'd0;
         r_frame    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_seg_s1   <= segin;
         r_seg_s2   <= r_seg_s1;
         r_an_s1    <= anin;
         r_an_s2    <= r_an_s1;
         r_prev_seg <= r_seg_s2;
         r_prev_an  <= r_an_s2;
         r_state    <= w_next_state;
         r_cnt      <= w_next_cnt;
         r_err      <= w_capture && (w_kind == c_k_bad);
         if (w_capture) begin
            case (w_kind)
               c_k_valid: begin
                  r_digits[{w_idx, 2'b00} +: 4] <= w_nib;
                  r_valid[w_idx]                <= 1'b1;
               end
               c_k_blank: begin
                  r_digits[{w_idx, 2'b00} +: 4] <= 4'd0;
                  r_valid[w_idx]                <= 1'b0;
               end
               default: r_valid[w_idx] <= 1'b0;
            endcase
         end
         // A full mask is reported and restarted in the same cycle.
         r_frame <= (r_seen == 4'hF);
         r_seen  <= (r_seen == 4'hF) ? w_cap_mask : (r_seen | w_cap_mask);
      end
   end

   assign digits      = r_digits;
   assign digit_valid = r_valid;
   assign frame_valid = r_frame;
   assign err         = r_err;

endmodule

`default_nettype wire
